fft_bitrev_reorder: RTL
=======================

# fft_bitrev_reorder

Final output stage of the 512-point FFT pipeline. It sits directly downstream of the block-floating-point denormalisation stage, which produces a full 512-sample 13-bit frame in bit-reversed order plus a one-cycle valid. This block captures each frame into a ping-pong buffer, restores natural frequency order, and streams the frame out at 16 samples per beat over 32 beats with valid/ready backpressure.

## Interface
Parameters:
- TOTAL_SIZE, 512, frame length; fixed at 512 (9-bit bit reversal).
- WIDTH, 13, sample width (signed).
- LANES, 16, samples per output beat; TOTAL_SIZE/LANES = 32 beats per frame.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- valid_input  in  1  one-cycle pulse; frame on bfly22_i/q is valid this cycle.
- bfly22_i  in  WIDTH x [0:TOTAL_SIZE-1]  signed real part, bit-reversed order.
- bfly22_q  in  WIDTH x [0:TOTAL_SIZE-1]  signed imaginary part, bit-reversed order.
- dout_ready  in  1  downstream accepts the current beat.
- dout_valid  out  1  beat valid.
- dout_i  out  WIDTH x [0:LANES-1]  real samples of the beat, natural order.
- dout_q  out  WIDTH x [0:LANES-1]  imaginary samples of the beat.
- dout_beat  out  5  beat number 0..31.
- dout_sof  out  1  dout_valid && beat==0.
- dout_eof  out  1  dout_valid && beat==31.
- frame_drop  out  1  one-cycle pulse when an incoming frame was discarded.
- busy  out  1  at least one bank holds an unsent frame.

## Operation
- Storage: two banks (0/1) of 512 complex samples, each with a full flag. Write select wr_sel and read select rd_sel are 1-bit registers. Storage contents are not reset.
- Capture: when valid_input is high and bank[wr_sel] is empty (or is being released this cycle, see below), store the whole frame in one cycle, set the full flag, and toggle wr_sel.
  - Permutation is applied at write time: bank[natural k] = bfly22[bitrev9(k)], where bitrev9 reverses bits [8:0].
  - Otherwise the frame is dropped: no state change, and frame_drop pulses in the next cycle.
- Read FSM, 2 states:
  - IDLE: dout_valid=0. If bank[rd_sel] is full, go to STREAM with beat=0.
  - STREAM: dout_valid=1. dout_i/q[l] = bank[rd_sel][beat*16+l].
- A transfer occurs when dout_valid && dout_ready.
  - On a transfer with beat<31: beat+1.
  - On a transfer with beat==31: clear the full flag of bank[rd_sel], toggle rd_sel, and set beat=0. If the other bank is full, stay in STREAM with no bubble; else go to IDLE.
- Without a transfer, beat and outputs hold stable (AXI-style: data must not change while valid && !ready).
- Release/capture collision: if the beat-31 transfer releases bank X in the same cycle valid_input targets bank X, the capture is accepted. Read data for that cycle comes from pre-edge contents.
- dout_i/q are driven 0 while dout_valid=0.
- busy = full[0] | full[1].
- No arithmetic; widths pass through unchanged.

## Timing
- Reset values: dout_valid=0, dout_i/q=0, dout_beat=0, dout_sof=0, dout_eof=0, frame_drop=0, busy=0, both banks empty, wr_sel=rd_sel=0, FSM=IDLE, beat=0.
- valid_input sampled at edge E:
  - The full flag is set at E, and busy=1 in cycle E+1.
  - The FSM enters STREAM at edge E+1, so dout_valid=1 from cycle E+2 (latency 2).
- With dout_ready held at 1, a frame takes exactly 32 consecutive valid cycles.
- Sustained throughput: one frame per 32 cycles with no gap between frames.
- frame_drop is asserted in the cycle after the dropped valid_input, for 1 cycle.
- Reset assertion mid-stream immediately clears all state and outputs (asynchronous). The partially sent frame and any buffered frame are lost. The first valid_input after release is captured into bank 0.

## Test plan
- Single frame, i[n]=n, q[n]=-n, ready=1:
  - dout_valid high for 32 cycles, starting 2 cycles after valid_input.
  - Beat 0 dout_i = 0,256,128,384,64,320,192,448,32,288,160,416,96,352,224,480.
  - Beat 1 lane 0 = 16; beat 31 lane 15 = 511; q is the negation of i.
  - sof is high on beat 0 and eof on beat 31.
- Backpressure: ready toggles 1,0,0,1… during the frame.
  - beat and data hold while ready=0; all 32 beats are delivered exactly once, in order.
- Back-to-back frames with valid_input every 32 cycles and ready=1:
  - dout_valid stays continuously high and the 64 beats are gap-free.
  - Frame B's beat 0 follows frame A's beat 31 with sof high.
- Overflow: three valid_input pulses 1 cycle apart with ready=0:
  - First two are accepted and busy=1; the third is dropped with a frame_drop pulse.
  - After ready=1, exactly frames 1 and 2 stream out.
- Collision: both banks full, and valid_input coincides with the beat-31 transfer:
  - The new frame is accepted with no frame_drop.
  - After the second frame finishes, the new frame streams with correct data.
- Reset asserted at beat 10 of a stream:
  - All outputs are 0 immediately and busy=0.
  - A new frame after release streams from beat 0 with correct data.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage of the 512-point FFT: captures bit-reversed frames into a
// ping-pong buffer and streams them out in natural order, LANES samples per beat.
module fft_bitrev_reorder #(
  parameter int unsigned TOTAL_SIZE = 512,
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned LANES      = 16,
  localparam int unsigned AW        = $clog2(TOTAL_SIZE),
  localparam int unsigned LW        = $clog2(LANES),
  localparam int unsigned BW        = AW - LW,
  localparam int unsigned BEATS     = TOTAL_SIZE / LANES
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_input,
  input  logic signed [WIDTH-1:0] bfly22_i [0:TOTAL_SIZE-1],
  input  logic signed [WIDTH-1:0] bfly22_q [0:TOTAL_SIZE-1],
  input  logic                    dout_ready,
  output logic                    dout_valid,
  output logic signed [WIDTH-1:0] dout_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_q [0:LANES-1],
  output logic [BW-1:0]           dout_beat,
  output logic                    dout_sof,
  output logic                    dout_eof,
  output logic                    frame_drop,
  output logic                    busy
);

  typedef enum logic {StIdle, StStream} state_e;

  state_e          r_state;
  logic [BW-1:0]   r_beat;
  logic            r_rd_sel;
  logic            r_wr_sel;
  logic [1:0]      r_full;
  logic            r_drop;

  logic signed [WIDTH-1:0] r_bank_i [2][TOTAL_SIZE];
  logic signed [WIDTH-1:0] r_bank_q [2][TOTAL_SIZE];

  logic       w_stream;
  logic       w_xfer;
  logic       w_last;
  logic       w_cap;
  logic [1:0] w_full_d;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = k[AW-1-b];
    return r;
  endfunction

  function automatic logic [AW-1:0] rd_idx(input logic [BW-1:0] beat, input int unsigned lane);
    return {beat, lane[LW-1:0]};
  endfunction

  assign w_stream = (r_state == StStream);
  assign w_xfer   = w_stream && dout_ready;
  assign w_last   = w_xfer && (r_beat == BW'(BEATS - 1));
  // A bank being released on this edge may be refilled on the same edge.
  assign w_cap    = valid_input && (!r_full[r_wr_sel] || (w_last && (r_rd_sel == r_wr_sel)));

  always_comb begin
    w_full_d = r_full;
    if (w_last) w_full_d[r_rd_sel] = 1'b0;
    if (w_cap)  w_full_d[r_wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StIdle;
      r_beat   <= '0;
      r_rd_sel <= 1'b0;
      r_wr_sel <= 1'b0;
      r_full   <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_full <= w_full_d;
      r_drop <= valid_input && !w_cap;
      if (w_cap) r_wr_sel <= ~r_wr_sel;
      unique case (r_state)
        StIdle: begin
          if (r_full[r_rd_sel]) begin
            r_state <= StStream;
            r_beat  <= '0;
          end
        end
        StStream: begin
          if (w_last) begin
            r_beat   <= '0;
            r_rd_sel <= ~r_rd_sel;
            // Pre-edge flag of the other bank decides whether to chain without a bubble.
            if (!r_full[~r_rd_sel]) r_state <= StIdle;
          end else if (w_xfer) begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Sample storage is not reset; the permutation is applied on write.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int k = 0; k < TOTAL_SIZE; k++) begin
        r_bank_i[r_wr_sel][k] <= bfly22_i[bitrev(AW'(k))];
        r_bank_q[r_wr_sel][k] <= bfly22_q[bitrev(AW'(k))];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      dout_i[l] = '0;
      dout_q[l] = '0;
      if (w_stream) begin
        dout_i[l] = r_bank_i[r_rd_sel][rd_idx(r_beat, l)];
        dout_q[l] = r_bank_q[r_rd_sel][rd_idx(r_beat, l)];
      end
    end
  end

  assign dout_valid = w_stream;
  assign dout_beat  = r_beat;
  assign dout_sof   = w_stream && (r_beat == '0);
  assign dout_eof   = w_stream && (r_beat == BW'(BEATS - 1));
  assign frame_drop = r_drop;
  assign busy       = |r_full;

endmodule
